// File: rtl/pc_unit.sv
// Architectural PC register with next-PC selection, trap entry/return and a
// RUN/HANDLER/HALT state machine that freezes the core on a double fault.
module pc_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              IALIGN       = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic [1:0]      pc_src,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] alu_result,
    input  logic            is_compressed,
    input  logic            trap_req,
    input  logic [XLEN-1:0] trap_vector,
    input  logic            mret,
    input  logic [XLEN-1:0] mepc_in,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus,
    output logic            exc_valid,
    output logic [1:0]      exc_cause,
    output logic [XLEN-1:0] exc_epc,
    output logic [XLEN-1:0] exc_tval,
    output logic            in_handler,
    output logic            halted
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_HANDLER,
        ST_HALT
    } state_t;

    localparam logic [1:0] CAUSE_MISALIGNED = 2'b00;
    localparam logic [1:0] CAUSE_TRAP       = 2'b01;

    localparam logic [XLEN-1:0] MRET_MASK = (IALIGN == 16) ?
        {{(XLEN-1){1'b1}}, 1'b0} : {{(XLEN-2){1'b1}}, 2'b00};

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            exc_valid_q, exc_valid_d;
    logic [1:0]      exc_cause_q, exc_cause_d;
    logic [XLEN-1:0] exc_epc_q, exc_epc_d;
    logic [XLEN-1:0] exc_tval_q, exc_tval_d;

    logic [XLEN-1:0] inst_len;
    logic [XLEN-1:0] seq_target;
    logic [XLEN-1:0] rel_target;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] trap_target;
    logic [XLEN-1:0] mret_target;
    logic            check_align;
    logic            misaligned;
    logic            trap_event;
    logic            unused_bits;

    assign unused_bits = ^{trap_vector[1:0], alu_result[0]};

    // Candidate target and alignment fault; only control transfers are checked.
    always_comb begin
        inst_len    = (IALIGN == 16 && is_compressed) ? XLEN'(2) : XLEN'(4);
        seq_target  = pc_q + inst_len;
        rel_target  = pc_q + imm;
        trap_target = {trap_vector[XLEN-1:2], 2'b00};
        mret_target = mepc_in & MRET_MASK;
        target      = seq_target;
        check_align = 1'b0;
        unique case (pc_src)
            2'b00: target = seq_target;
            2'b01: begin
                target      = branch_taken ? rel_target : seq_target;
                check_align = branch_taken;
            end
            2'b10: begin
                target      = rel_target;
                check_align = 1'b1;
            end
            default: begin
                target      = {alu_result[XLEN-1:1], 1'b0};
                check_align = 1'b1;
            end
        endcase
        if (IALIGN == 16) begin
            misaligned = check_align && target[0];
        end else begin
            misaligned = check_align && (target[1:0] != 2'b00);
        end
        trap_event = trap_req || misaligned;
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        exc_valid_d = 1'b0;
        exc_cause_d = exc_cause_q;
        exc_epc_d   = exc_epc_q;
        exc_tval_d  = exc_tval_q;
        if (state_q == ST_HALT || stall) begin
            state_d = state_q;
        end else if (trap_event) begin
            // A fault inside the handler is unrecoverable: freeze everything.
            if (state_q == ST_HANDLER) begin
                state_d = ST_HALT;
            end else begin
                state_d     = ST_HANDLER;
                pc_d        = trap_target;
                exc_valid_d = 1'b1;
                exc_epc_d   = pc_q;
                exc_cause_d = trap_req ? CAUSE_TRAP : CAUSE_MISALIGNED;
                exc_tval_d  = trap_req ? '0 : target;
            end
        end else if (mret) begin
            state_d = ST_RUN;
            pc_d    = mret_target;
        end else begin
            pc_d = target;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            pc_q        <= RESET_VECTOR;
            exc_valid_q <= 1'b0;
            exc_cause_q <= 2'b00;
            exc_epc_q   <= '0;
            exc_tval_q  <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            exc_valid_q <= exc_valid_d;
            exc_cause_q <= exc_cause_d;
            exc_epc_q   <= exc_epc_d;
            exc_tval_q  <= exc_tval_d;
        end
    end

    assign pc         = pc_q;
    assign pc_plus    = seq_target;
    assign exc_valid  = exc_valid_q;
    assign exc_cause  = exc_cause_q;
    assign exc_epc    = exc_epc_q;
    assign exc_tval   = exc_tval_q;
    assign in_handler = (state_q == ST_HANDLER);
    assign halted     = (state_q == ST_HALT);

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: a 32-bit-aligned and a 16-bit-aligned instance
// share one stimulus set; each test task checks its own expectations inline.
module tb_pc_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic [1:0]  pc_src;
    logic        branch_taken;
    logic [31:0] imm;
    logic [31:0] alu_result;
    logic        is_compressed;
    logic        trap_req;
    logic [31:0] trap_vector;
    logic        mret;
    logic [31:0] mepc_in;

    logic [31:0] pc, pc_plus, exc_epc, exc_tval;
    logic        exc_valid, in_handler, halted;
    logic [1:0]  exc_cause;

    logic [31:0] pc_c, pc_plus_c, exc_epc_c, exc_tval_c;
    logic        exc_valid_c, in_handler_c, halted_c;
    logic [1:0]  exc_cause_c;

    int total = 0;
    int bad   = 0;

    pc_unit #(.XLEN(32), .RESET_VECTOR(32'h0), .IALIGN(32)) u_dut (
        .clk(clk), .rst(rst), .stall(stall), .pc_src(pc_src),
        .branch_taken(branch_taken), .imm(imm), .alu_result(alu_result),
        .is_compressed(is_compressed), .trap_req(trap_req),
        .trap_vector(trap_vector), .mret(mret), .mepc_in(mepc_in),
        .pc(pc), .pc_plus(pc_plus), .exc_valid(exc_valid),
        .exc_cause(exc_cause), .exc_epc(exc_epc), .exc_tval(exc_tval),
        .in_handler(in_handler), .halted(halted)
    );

    pc_unit #(.XLEN(32), .RESET_VECTOR(32'h0), .IALIGN(16)) u_dut_c (
        .clk(clk), .rst(rst), .stall(stall), .pc_src(pc_src),
        .branch_taken(branch_taken), .imm(imm), .alu_result(alu_result),
        .is_compressed(is_compressed), .trap_req(trap_req),
        .trap_vector(trap_vector), .mret(mret), .mepc_in(mepc_in),
        .pc(pc_c), .pc_plus(pc_plus_c), .exc_valid(exc_valid_c),
        .exc_cause(exc_cause_c), .exc_epc(exc_epc_c), .exc_tval(exc_tval_c),
        .in_handler(in_handler_c), .halted(halted_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle so outputs are sampled away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst           = 1'b0;
        stall         = 1'b0;
        pc_src        = 2'b00;
        branch_taken  = 1'b0;
        imm           = 32'h0;
        alu_result    = 32'h0;
        is_compressed = 1'b0;
        trap_req      = 1'b0;
        trap_vector   = 32'h8000_0003;
        mret          = 1'b0;
        mepc_in       = 32'h0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Uses mret from RUN to place the PC at an arbitrary aligned address.
    task automatic jump_to(input logic [31:0] addr);
        idle_inputs();
        mret    = 1'b1;
        mepc_in = addr;
        step();
        idle_inputs();
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (pc !== 32'h0) begin
            bad++;
            $display("[TB] FAIL reset_pc: got %h want %h", pc, 32'h0);
        end
        total++;
        if ({exc_valid, in_handler, halted, exc_cause} !== 5'b0) begin
            bad++;
            $display("[TB] FAIL reset_flags: got %b want %b",
                     {exc_valid, in_handler, halted, exc_cause}, 5'b0);
        end
        total++;
        if (exc_epc !== 32'h0 || exc_tval !== 32'h0) begin
            bad++;
            $display("[TB] FAIL reset_epc_tval: got %h/%h want 0/0", exc_epc, exc_tval);
        end
    endtask

    task automatic test_sequential();
        for (int i = 1; i <= 3; i++) begin
            step();
            total++;
            if (pc !== 32'(i * 4) || exc_valid !== 1'b0 || in_handler !== 1'b0) begin
                bad++;
                $display("[TB] FAIL seq_pc_%0d: got pc=%h ev=%b ih=%b want pc=%h ev=0 ih=0",
                         i, pc, exc_valid, in_handler, 32'(i * 4));
            end
        end
    endtask

    task automatic test_compressed();
        do_reset();
        jump_to(32'h100);
        is_compressed = 1'b1;
        #1;
        total++;
        if (pc_plus_c !== 32'h102) begin
            bad++;
            $display("[TB] FAIL c16_pc_plus: got %h want %h", pc_plus_c, 32'h102);
        end
        total++;
        if (pc_plus !== 32'h104) begin
            bad++;
            $display("[TB] FAIL c32_ignores_compressed: got %h want %h", pc_plus, 32'h104);
        end
        step();
        total++;
        if (pc_c !== 32'h102) begin
            bad++;
            $display("[TB] FAIL c16_seq: got %h want %h", pc_c, 32'h102);
        end
        is_compressed = 1'b0;
        pc_src        = 2'b11;
        alu_result    = 32'h203;
        step();
        total++;
        if (pc_c !== 32'h202 || exc_valid_c !== 1'b0 || in_handler_c !== 1'b0) begin
            bad++;
            $display("[TB] FAIL c16_jalr: got pc=%h ev=%b ih=%b want pc=00000202 ev=0 ih=0",
                     pc_c, exc_valid_c, in_handler_c);
        end
    endtask

    task automatic test_misaligned_jal();
        do_reset();
        jump_to(32'h40);
        pc_src = 2'b10;
        imm    = 32'h6;
        step();
        total++;
        if (pc !== 32'h8000_0000) begin
            bad++;
            $display("[TB] FAIL jal_trap_pc: got %h want %h", pc, 32'h8000_0000);
        end
        total++;
        if (exc_valid !== 1'b1 || exc_cause !== 2'b00 || in_handler !== 1'b1) begin
            bad++;
            $display("[TB] FAIL jal_exc_flags: got ev=%b cause=%b ih=%b want ev=1 cause=00 ih=1",
                     exc_valid, exc_cause, in_handler);
        end
        total++;
        if (exc_epc !== 32'h40 || exc_tval !== 32'h46) begin
            bad++;
            $display("[TB] FAIL jal_epc_tval: got %h/%h want 00000040/00000046", exc_epc, exc_tval);
        end
        idle_inputs();
        mret    = 1'b1;
        mepc_in = 32'h44;
        step();
        total++;
        if (pc !== 32'h44 || in_handler !== 1'b0 || exc_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL mret_return: got pc=%h ih=%b ev=%b want pc=00000044 ih=0 ev=0",
                     pc, in_handler, exc_valid);
        end
        idle_inputs();
    endtask

    task automatic test_stall();
        stall    = 1'b1;
        trap_req = 1'b1;
        pc_src   = 2'b10;
        imm      = 32'h8;
        for (int i = 0; i < 2; i++) begin
            step();
            total++;
            if (pc !== 32'h44 || exc_valid !== 1'b0 || in_handler !== 1'b0) begin
                bad++;
                $display("[TB] FAIL stall_hold_%0d: got pc=%h ev=%b ih=%b want pc=00000044 ev=0 ih=0",
                         i, pc, exc_valid, in_handler);
            end
        end
        stall = 1'b0;
        step();
        total++;
        if (pc !== 32'h8000_0000 || exc_valid !== 1'b1 || exc_cause !== 2'b01) begin
            bad++;
            $display("[TB] FAIL stall_release_trap: got pc=%h ev=%b cause=%b want pc=80000000 ev=1 cause=01",
                     pc, exc_valid, exc_cause);
        end
        total++;
        if (exc_tval !== 32'h0 || exc_epc !== 32'h44) begin
            bad++;
            $display("[TB] FAIL stall_trap_tval_epc: got %h/%h want 00000000/00000044", exc_tval, exc_epc);
        end
        idle_inputs();
        step();
        total++;
        if (pc !== 32'h8000_0004 || exc_valid !== 1'b0 || in_handler !== 1'b1) begin
            bad++;
            $display("[TB] FAIL handler_seq: got pc=%h ev=%b ih=%b want pc=80000004 ev=0 ih=1",
                     pc, exc_valid, in_handler);
        end
    endtask

    task automatic test_double_fault();
        trap_req = 1'b1;
        step();
        total++;
        if (halted !== 1'b1 || pc !== 32'h8000_0004 || exc_valid !== 1'b0 || in_handler !== 1'b0) begin
            bad++;
            $display("[TB] FAIL double_fault: got h=%b pc=%h ev=%b ih=%b want h=1 pc=80000004 ev=0 ih=0",
                     halted, pc, exc_valid, in_handler);
        end
        idle_inputs();
        mret    = 1'b1;
        mepc_in = 32'h10;
        for (int i = 0; i < 5; i++) begin
            step();
            total++;
            if (halted !== 1'b1 || pc !== 32'h8000_0004 || exc_valid !== 1'b0) begin
                bad++;
                $display("[TB] FAIL halt_frozen_%0d: got h=%b pc=%h ev=%b want h=1 pc=80000004 ev=0",
                         i, halted, pc, exc_valid);
            end
        end
        do_reset();
        total++;
        if (pc !== 32'h0 || halted !== 1'b0 || in_handler !== 1'b0 || exc_epc !== 32'h0) begin
            bad++;
            $display("[TB] FAIL halt_reset: got pc=%h h=%b ih=%b epc=%h want 0/0/0/0",
                     pc, halted, in_handler, exc_epc);
        end
    endtask

    task automatic test_wrap_and_priority();
        do_reset();
        jump_to(32'hFFFF_FFFC);
        step();
        total++;
        if (pc !== 32'h0 || exc_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL wrap_pc: got pc=%h ev=%b want pc=00000000 ev=0", pc, exc_valid);
        end
        jump_to(32'hFFFF_FFFC);
        pc_src       = 2'b01;
        branch_taken = 1'b1;
        imm          = 32'h2;
        trap_req     = 1'b1;
        step();
        total++;
        if (exc_valid !== 1'b1 || exc_cause !== 2'b01 || exc_tval !== 32'h0) begin
            bad++;
            $display("[TB] FAIL trap_beats_misaligned: got ev=%b cause=%b tval=%h want ev=1 cause=01 tval=0",
                     exc_valid, exc_cause, exc_tval);
        end
        total++;
        if (exc_epc !== 32'hFFFF_FFFC || pc !== 32'h8000_0000) begin
            bad++;
            $display("[TB] FAIL trap_beats_epc_pc: got epc=%h pc=%h want fffffffc/80000000", exc_epc, pc);
        end
    endtask

    task automatic test_branch();
        do_reset();
        jump_to(32'h20);
        pc_src       = 2'b01;
        branch_taken = 1'b0;
        imm          = 32'h2;
        step();
        total++;
        if (pc !== 32'h24 || exc_valid !== 1'b0 || in_handler !== 1'b0) begin
            bad++;
            $display("[TB] FAIL branch_not_taken: got pc=%h ev=%b ih=%b want pc=00000024 ev=0 ih=0",
                     pc, exc_valid, in_handler);
        end
        branch_taken = 1'b1;
        step();
        total++;
        if (exc_valid !== 1'b1 || exc_cause !== 2'b00 || exc_tval !== 32'h26 || exc_epc !== 32'h24) begin
            bad++;
            $display("[TB] FAIL branch_misaligned: got ev=%b cause=%b tval=%h epc=%h want 1/00/00000026/00000024",
                     exc_valid, exc_cause, exc_tval, exc_epc);
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_sequential();
        test_compressed();
        test_misaligned_jal();
        test_stall();
        test_double_fault();
        test_wrap_and_priority();
        test_branch();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised successor of the combinational next-PC selector.
- Owns the architectural PC register and computes the next PC from sequential, branch, JAL and JALR sources, with optional 16-bit instruction alignment.
- Adds stall hold, trap entry/return (mret), instruction-address-misaligned detection and a run/handler/halt state machine for double faults.
- Sits between the decoder/ALU/CSR file and instruction memory; pc drives the fetch address.

Parameters:
XLEN, 32, datapath and PC width.
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
IALIGN, 32, instruction alignment in bits; legal values are 32 or 16 (16 enables the C extension).

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  reset; synchronous, active-high.
stall  in  1  hold all state this cycle.
pc_src  in  2  next-PC source: 00 PC+len, 01 branch, 10 JAL, 11 JALR.
branch_taken  in  1  branch condition result; used only when pc_src=01.
imm  in  XLEN  sign-extended immediate offset.
alu_result  in  XLEN  JALR target before masking.
is_compressed  in  1  current instruction is 16-bit; ignored when IALIGN=32.
trap_req  in  1  external/synchronous trap request (ecall, illegal instruction, ...).
trap_vector  in  XLEN  handler base (mtvec, direct mode).
mret  in  1  return from handler.
mepc_in  in  XLEN  return address for mret.
pc  out  XLEN  current PC (registered).
pc_plus  out  XLEN  pc + instruction length; combinational, used as the link value.
exc_valid  out  1  registered one-cycle pulse: trap entry occurred.
exc_cause  out  2  00 misaligned target, 01 trap_req; valid with exc_valid.
exc_epc  out  XLEN  PC of the trapping instruction.
exc_tval  out  XLEN  faulting target for cause 00; 0 for cause 01.
in_handler  out  1  FSM is in HANDLER.
halted  out  1  FSM is in HALT.

Behaviour:
- Reset (rst=1 at a clock edge, highest priority, also mid-handler or in HALT):
  - pc=RESET_VECTOR; FSM=RUN.
  - exc_valid=0, exc_cause=0, exc_epc=0, exc_tval=0.
- Instruction length: len=2 when IALIGN=16 and is_compressed=1, else 4. pc_plus=pc+len, XLEN-bit wrap-around, no overflow flag.
- Candidate target:
  - 00: pc_plus.
  - 01: pc+imm if branch_taken, else pc_plus.
  - 10: pc+imm.
  - 11: {alu_result[XLEN-1:1],1'b0}.
  - All additions are modulo 2^XLEN.
- Misaligned check applies to the candidate only when it is a taken branch, a JAL or a JALR:
  - IALIGN=32: fault if target[1:0]!=0 (for JALR only bit 1 can fault).
  - IALIGN=16: fault if target[0]!=0, so JALR never faults.
  - A not-taken branch never faults.
- Trap target: {trap_vector[XLEN-1:2],2'b00}. mret target: mepc_in with the low bits cleared to the IALIGN boundary.
- Per-edge priority, top wins:
  1. rst.
  2. FSM=HALT: pc holds.
  3. stall=1: pc, FSM and exc_* hold; exc_valid=0; trap_req, mret and faults are ignored, so sources must hold requests until unstalled.
  4. Trap event (trap_req=1 or misaligned fault):
     - pc <= trap target; exc_valid pulses next cycle.
     - exc_epc <= pc.
     - Cause: trap_req beats misaligned when both occur, giving cause 01 with tval 0; otherwise cause 00 with tval = candidate target.
  5. mret=1: pc <= mret target.
  6. Otherwise pc <= candidate target.
- FSM:
  - RUN, trap event -> HANDLER (trap taken).
  - RUN, mret -> RUN (pc <= mepc).
  - HANDLER, mret -> RUN.
  - HANDLER, trap event -> HALT (double fault). No exc_valid pulse; pc frozen at the value held when the fault occurred.
  - HALT: absorbing; left only by rst.
  - mret together with a trap event: the trap wins.
- exc_valid is high exactly one cycle after the accepting edge. It is never high while stalled, or in the cycle after entering HALT.
- Latency: the next-PC decision is combinational; pc updates one edge later. There are no bubbles.

Test Plan:
- Reset, then 3 unstalled cycles with pc_src=00, IALIGN=32 -> pc = 0, 4, 8, 12; exc_valid stays 0; in_handler=0.
- IALIGN=16, pc=0x100, is_compressed=1, pc_src=00 -> pc=0x102. Then JALR with alu_result=0x203 -> pc=0x202 and no fault.
- IALIGN=32, pc=0x40, JAL imm=0x6:
  - pc becomes 0x8000_0000 (trap_vector=0x8000_0003, masked).
  - Next cycle: exc_valid=1, cause=00, epc=0x40, tval=0x46, in_handler=1.
  - Then mret with mepc_in=0x44 -> pc=0x44, FSM back to RUN.
- stall=1 held for 2 cycles with trap_req=1 and pc_src=10 -> pc unchanged, exc_valid=0. Release stall -> trap taken with cause 01, tval 0.
- In HANDLER, assert trap_req -> halted=1, pc frozen for 5+ cycles, no exc_valid pulse. Then rst=1 -> pc=RESET_VECTOR, halted=0.
- Wrap-around: pc=0xFFFF_FFFC, pc_src=00 -> pc=0x0000_0000. Same cycle as a branch-taken misalignment with trap_req -> cause 01 wins.
